// File: rtl/min_max_tracker.sv
// Frame-based min/max tracker: accumulates FRAME_LEN samples, then holds min/max/count until taken.
// Define MINMAX_SIGNED_EN to compare samples as two's complement instead of unsigned.
module min_max_tracker #(
  parameter int FRAME_LEN = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_min,
  output logic [7:0] out_max,
  output logic [7:0] count
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam logic [7:0] LAST = 8'(FRAME_LEN - 1);

  state_t     state_q, state_d;
  logic [7:0] min_q, max_q, cnt_q;
  logic       in_xfer, out_xfer;

  function automatic logic lt(input logic [7:0] a, input logic [7:0] b);
`ifdef MINMAX_SIGNED_EN
    return $signed(a) < $signed(b);
`else
    return a < b;
`endif
  endfunction

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) state_d = IDLE;
    else begin
      case (state_q)
        IDLE:    if (in_xfer) state_d = ACCUM;
        ACCUM:   if (in_xfer && cnt_q == LAST) state_d = HOLD;
        HOLD:    if (out_xfer) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q != HOLD);
    out_valid = (state_q == HOLD);
  end

  // Strict compares so equal samples never rewrite min/max.
  always_ff @(posedge clk) begin
    if (rst) begin
      min_q <= 8'h00;
      max_q <= 8'h00;
      cnt_q <= 8'h00;
    end else if (clear) begin
      cnt_q <= 8'h00;
    end else begin
      case (state_q)
        IDLE: if (in_xfer) begin
          min_q <= in_data;
          max_q <= in_data;
          cnt_q <= 8'd1;
        end
        ACCUM: if (in_xfer) begin
          if (lt(in_data, min_q)) min_q <= in_data;
          if (lt(max_q, in_data)) max_q <= in_data;
          cnt_q <= cnt_q + 8'd1;
        end
        HOLD: if (out_xfer) cnt_q <= 8'h00;
        default: ;
      endcase
    end
  end

  assign out_min = min_q;
  assign out_max = max_q;
  assign count   = cnt_q;

endmodule

// File: tb/tb_min_max_tracker.sv
// Directed bench: three trackers (FRAME_LEN 8, 4, 2) on one clock, checked by immediate assertions.
module tb_min_max_tracker;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]      rst, clr, iv, ordy;
  logic [2:0][7:0] id;
  wire  [2:0]      irdy, ov;
  wire  [2:0][7:0] omin, omax, ocnt;

  int nvec = 0;
  int nerr = 0;

  min_max_tracker #(.FRAME_LEN(8)) u8 (
    .clk(clk), .rst(rst[0]), .clear(clr[0]), .in_valid(iv[0]), .in_data(id[0]),
    .in_ready(irdy[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_min(omin[0]), .out_max(omax[0]), .count(ocnt[0]));
  min_max_tracker #(.FRAME_LEN(4)) u4 (
    .clk(clk), .rst(rst[1]), .clear(clr[1]), .in_valid(iv[1]), .in_data(id[1]),
    .in_ready(irdy[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_min(omin[1]), .out_max(omax[1]), .count(ocnt[1]));
  min_max_tracker #(.FRAME_LEN(2)) u2 (
    .clk(clk), .rst(rst[2]), .clear(clr[2]), .in_valid(iv[2]), .in_data(id[2]),
    .in_ready(irdy[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
    .out_min(omin[2]), .out_max(omax[2]), .count(ocnt[2]));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change on negedge; after cyc we sit at the next negedge with outputs settled.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_all(input int k, input string tag, input logic r, input logic v,
                         input logic [7:0] mn, input logic [7:0] mx, input logic [7:0] c);
    chk({tag, "_rdy"}, {7'd0, irdy[k]}, {7'd0, r});
    chk({tag, "_ov"},  {7'd0, ov[k]},   {7'd0, v});
    chk({tag, "_min"}, omin[k], mn);
    chk({tag, "_max"}, omax[k], mx);
    chk({tag, "_cnt"}, ocnt[k], c);
  endtask

  logic [7:0] sa [8] = '{8'd5, 8'd3, 8'd9, 8'd3, 8'd200, 8'd0, 8'd7, 8'd9};
  logic [7:0] sb [4] = '{8'd10, 8'd20, 8'd30, 8'd40};
  logic [7:0] sd [4] = '{8'h80, 8'h7F, 8'h01, 8'hFF};

  initial begin
    rst = '1; clr = '0; iv = '0; ordy = '0; id = '0;
    @(negedge clk);
    cyc();
    for (int k = 0; k < 3; k++) chk_all(k, "reset", 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    rst = '0;
    cyc();
    chk("post_rst_rdy", {7'd0, irdy[0]}, 8'd1);

    // FRAME_LEN=8, back-to-back samples, consumer always ready
    ordy[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      iv[0] = 1'b1; id[0] = sa[i];
      cyc();
      if (i == 3) chk("a_cnt4", ocnt[0], 8'd4);
    end
    iv[0] = 1'b0;
    chk_all(0, "a_hold", 1'b0, 1'b1, 8'd0, 8'd200, 8'd8);
    cyc();
    chk_all(0, "a_idle", 1'b1, 1'b0, 8'd0, 8'd200, 8'd0);

    // FRAME_LEN=4, in_valid toggling, consumer stalls 5 cycles
    for (int i = 0; i < 4; i++) begin
      iv[1] = 1'b1; id[1] = sb[i];
      cyc();
      iv[1] = 1'b0;
      if (i < 3) cyc();
    end
    for (int i = 0; i < 5; i++) begin
      iv[1] = 1'b1; id[1] = 8'h01;
      cyc();
      chk_all(1, "b_stall", 1'b0, 1'b1, 8'd10, 8'd40, 8'd4);
    end
    iv[1] = 1'b0; ordy[1] = 1'b1;
    cyc();
    ordy[1] = 1'b0;
    chk_all(1, "b_rel", 1'b1, 1'b0, 8'd10, 8'd40, 8'd0);

    // clear on the 3rd sample of a frame, then a frame of equal samples
    iv[1] = 1'b1; id[1] = 8'd50; cyc();
    id[1] = 8'd60; cyc();
    chk("c_cnt2", ocnt[1], 8'd2);
    id[1] = 8'd1; clr[1] = 1'b1; cyc();
    clr[1] = 1'b0; iv[1] = 1'b0;
    chk_all(1, "c_clr", 1'b1, 1'b0, 8'd50, 8'd60, 8'd0);
    for (int i = 0; i < 4; i++) begin
      iv[1] = 1'b1; id[1] = 8'd7; cyc();
    end
    iv[1] = 1'b0;
    chk_all(1, "c_eq", 1'b0, 1'b1, 8'd7, 8'd7, 8'd4);
    ordy[1] = 1'b1; cyc(); ordy[1] = 1'b0;

    // signedness, then reset while holding a result
    for (int i = 0; i < 4; i++) begin
      iv[1] = 1'b1; id[1] = sd[i]; cyc();
    end
    iv[1] = 1'b0;
`ifdef MINMAX_SIGNED_EN
    chk_all(1, "d_sgn", 1'b0, 1'b1, 8'h80, 8'h7F, 8'd4);
`else
    chk_all(1, "d_uns", 1'b0, 1'b1, 8'h01, 8'hFF, 8'd4);
`endif
    rst[1] = 1'b1; cyc(); rst[1] = 1'b0;
    chk_all(1, "d_rst", 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);

    // FRAME_LEN=2, in_valid held high: accept, accept, hold gap, repeat
    ordy[2] = 1'b1;
    for (int i = 0; i < 9; i++) begin
      iv[2] = 1'b1; id[2] = 8'(10 + i);
      chk("e_rdy", {7'd0, irdy[2]}, {7'd0, (i % 3) != 2});
      cyc();
      if (i % 3 == 1) chk_all(2, "e_hold", 1'b0, 1'b1, 8'(9 + i), 8'(10 + i), 8'd2);
    end
    iv[2] = 1'b0;
    chk_all(2, "e_end", 1'b1, 1'b0, 8'd16, 8'd17, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/min_max_tracker.md
MIN_MAX_TRACKER -- requirements
Module: min_max_tracker

Interface
REQ-001 Parameter FRAME_LEN, default 8, is the number of samples per frame; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 clear  input  1  synchronous frame abort.
REQ-005 in_valid  input  1  in_data holds a sample.
REQ-006 in_data  input  8  sample value.
REQ-007 in_ready  output  1  block can accept a sample this cycle.
REQ-008 out_valid  output  1  frame result available.
REQ-009 out_ready  input  1  consumer takes the result this cycle.
REQ-010 out_min  output  8  minimum sample of the frame.
REQ-011 out_max  output  8  maximum sample of the frame.
REQ-012 count  output  8  samples accepted in the current frame.

Function
REQ-013 Input transfer SHALL occur only on a cycle where in_valid=1 and in_ready=1; output transfer SHALL occur only on a cycle where out_valid=1 and out_ready=1.
REQ-014 FSM SHALL have states IDLE, ACCUM and HOLD; in_ready=1 in IDLE and ACCUM, 0 in HOLD; out_valid=1 only in HOLD.
REQ-015 IDLE + input transfer: min<=in_data, max<=in_data, count<=1, next state ACCUM.
REQ-016 ACCUM + input transfer: min<=in_data if in_data<min (strict), max<=in_data if max<in_data (strict), count<=count+1.
REQ-017 Transfer of the FRAME_LEN-th sample (count==FRAME_LEN-1 before update) SHALL apply REQ-016 and move to HOLD; out_valid SHALL assert on the following cycle (latency 1 cycle after last sample).
REQ-018 ACCUM with no transfer: all state holds; in_valid may be low for any number of cycles.
REQ-019 HOLD: out_min, out_max and count SHALL remain stable until output transfer; in_data SHALL be ignored.
REQ-020 HOLD + output transfer: next state IDLE, out_valid=0 next cycle; no same-cycle sample acceptance (no bypass).
REQ-021 Equal samples SHALL NOT change min or max.
REQ-022 count SHALL never exceed FRAME_LEN; no wrap-around.
REQ-023 In IDLE, out_min, out_max and count SHALL retain their last values except count, which SHALL read 0.
REQ-024 clear=1 (in any state): next state IDLE, count<=0, out_valid=0 next cycle; samples and output transfers on that cycle SHALL be discarded; out_min/out_max hold.
REQ-025 Comparison SHALL be unsigned 8-bit unless REQ-030 applies.

Reset
REQ-026 rst SHALL be synchronous and active-high; it SHALL take priority over clear and all handshakes.
REQ-027 On reset: state IDLE, in_ready=1, out_valid=0, out_min=8'h00, out_max=8'h00, count=0.
REQ-028 Reset asserted mid-frame or in HOLD SHALL discard the partial or pending result with no output transfer.
REQ-029 in_ready SHALL be 1 on the first cycle after rst deasserts.

Configuration
REQ-030 Macro MINMAX_SIGNED_EN: when defined, in_data, out_min and out_max SHALL be treated as two's complement for all comparisons; when undefined, comparisons SHALL be unsigned; handshake and timing SHALL be identical in both builds.

Verification
REQ-031 FRAME_LEN=8, samples 5,3,9,3,200,0,7,9 back-to-back, out_ready=1 -> out_valid one cycle after 8th transfer with out_min=0, out_max=200, count=8; one-cycle HOLD, then IDLE.
REQ-032 FRAME_LEN=4, samples 10,20,30,40 with in_valid toggling every other cycle, out_ready held 0 for 5 cycles -> in_ready=0 and outputs 10/40/4 stable throughout; released on out_ready=1.
REQ-033 clear on the cycle the 3rd of 4 samples arrives -> sample discarded, count=0 next cycle, next frame 7,7,7,7 -> out_min=7, out_max=7.
REQ-034 rst asserted while in HOLD with out_ready=0 -> next cycle out_valid=0, in_ready=1, out_min=out_max=0, count=0.
REQ-035 Samples 8'h80,8'h7F,8'h01,8'hFF (FRAME_LEN=4): without MINMAX_SIGNED_EN -> min=8'h01, max=8'hFF; with it -> min=8'h80, max=8'h7F.
REQ-036 FRAME_LEN=2, back-to-back frames with out_ready=1 -> exactly one idle-ready cycle gap per frame, no sample lost or counted twice.
